// File: rtl/serial_word_rx.sv
// -----------------------------------------------------------------------------
// serial_word_rx
//
// Purpose:
//   Assembles a serial bit stream into a WIDTH-bit parallel word. A frame
//   begins with a start request, collects WIDTH qualified bits, and then
//   presents the word until the consumer accepts it with a ready/valid
//   handshake.
//
// Optional feature (compile-time macro): PARITY_CHK_EN
//   When defined, one even-parity bit follows the data bits. The parity
//   result is reported on par_err while the word is held. When undefined,
//   frames are exactly WIDTH bits and par_err is tied low.
//
// Parameters:
//   WIDTH     : data word width in bits (2..32)
//   LSB_FIRST : 1 = first received bit ends in par_out[0],
//               0 = first received bit ends in par_out[WIDTH-1]
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : asynchronous active-high reset
//   start     : frame start request (aborts a frame in progress)
//   ser_in    : serial data bit
//   ser_valid : qualifies ser_in, one bit per cycle when high
//   out_ready : consumer accepts the held word
//   clr_err   : synchronous clear of the sticky overrun flag
//   par_out   : assembled word (in-progress shift contents outside HOLD)
//   out_valid : par_out holds a complete word
//   busy      : frame reception in progress
//   overrun   : sticky, a start was dropped while a word was pending
//   par_err   : parity mismatch on the held word
// -----------------------------------------------------------------------------
module serial_word_rx #(
  parameter int WIDTH     = 16,
  parameter int LSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] par_out,
  output logic             out_valid,
  output logic             busy,
  output logic             overrun,
  output logic             par_err
);

  // Counter must be able to hold the value WIDTH after the final data bit.
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
`ifdef PARITY_CHK_EN
    ST_PARITY = 2'd2,
`endif
    ST_HOLD   = 2'd3
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shift;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_overrun;
  logic             w_ovr_set;

  // Shift one bit into the word in the configured direction. For LSB-first
  // the newest bit enters at the MSB so that after WIDTH bits the first one
  // has travelled down to bit 0.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                input logic             bit_in);
    logic [WIDTH-1:0] nxt;
    if (LSB_FIRST != 0) begin
      nxt = {bit_in, cur[WIDTH-1:1]};
    end else begin
      nxt = {cur[WIDTH-2:0], bit_in};
    end
    return nxt;
  endfunction

`ifdef PARITY_CHK_EN
  logic r_par_err;
  logic w_take_start;

  // Even parity: data plus parity bit must XOR to zero; a 1 flags an error.
  function automatic logic even_parity_err(input logic [WIDTH-1:0] data,
                                           input logic             par_bit);
    return (^data) ^ par_bit;
  endfunction

  // A start is consumed (rather than dropped) everywhere except a HOLD
  // without handshake; each consumed start clears the previous parity result.
  always_comb begin
    w_take_start = 1'b0;
    case (r_state)
      ST_IDLE, ST_SHIFT, ST_PARITY: w_take_start = start;
      ST_HOLD:                      w_take_start = start & out_ready;
      default:                      w_take_start = 1'b0;
    endcase
  end
`endif

  // A start arriving while a word waits unaccepted is lost; flag it.
  always_comb begin
    w_ovr_set = 1'b0;
    if (r_state == ST_HOLD) begin
      w_ovr_set = start & ~out_ready;
    end else begin
      w_ovr_set = 1'b0;
    end
  end

  // Receive FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= CNT_ZERO;
      r_shift     <= {WIDTH{1'b0}};
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef PARITY_CHK_EN
      r_par_err   <= 1'b0;
`endif
    end else begin
`ifdef PARITY_CHK_EN
      // Placed before the case so the parity result written on entry to
      // HOLD is never overridden (that branch is exclusive with start).
      if (w_take_start) begin
        r_par_err <= 1'b0;
      end
`endif
      case (r_state)
        ST_IDLE: begin
          // Serial input is ignored until a start arrives.
          if (start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b1;
          end
        end

        ST_SHIFT: begin
          if (start) begin
            // Abort: restart collection from scratch, stay in SHIFT.
            r_cnt   <= CNT_ZERO;
            r_shift <= {WIDTH{1'b0}};
          end else if (ser_valid) begin
            r_shift <= shift_in(r_shift, ser_in);
            r_cnt   <= r_cnt + CNT_ONE;
            if (r_cnt == LAST_BIT) begin
`ifdef PARITY_CHK_EN
              r_state     <= ST_PARITY;
`else
              r_state     <= ST_HOLD;
              r_out_valid <= 1'b1;
              r_busy      <= 1'b0;
`endif
            end
          end
        end

`ifdef PARITY_CHK_EN
        ST_PARITY: begin
          if (start) begin
            r_state <= ST_SHIFT;
            r_cnt   <= CNT_ZERO;
            r_shift <= {WIDTH{1'b0}};
          end else if (ser_valid) begin
            // The parity bit is checked but not stored in the word.
            r_par_err   <= even_parity_err(r_shift, ser_in);
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
`endif

        ST_HOLD: begin
          // out_valid is always high here, so out_ready alone completes
          // the handshake. Without it, par_out and the state are frozen.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (start) begin
              r_state <= ST_SHIFT;
              r_cnt   <= CNT_ZERO;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= CNT_ZERO;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase

      // Set wins over a simultaneous clear.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clr_err) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign par_out   = r_shift;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign overrun   = r_overrun;
`ifdef PARITY_CHK_EN
  assign par_err   = r_par_err;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;

  localparam int WIDTH     = 16;
  localparam int LSB_FIRST = 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             ser_in = 1'b0;
  logic             ser_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic             clr_err = 1'b0;
  logic [WIDTH-1:0] par_out;
  logic             out_valid;
  logic             busy;
  logic             overrun;
  logic             par_err;

  int n_vec  = 0;
  int n_fail = 0;

  serial_word_rx #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .out_ready (out_ready),
    .clr_err   (clr_err),
    .par_out   (par_out),
    .out_valid (out_valid),
    .busy      (busy),
    .overrun   (overrun),
    .par_err   (par_err)
  );

  always #5 clk = ~clk;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Which word bit is transmitted at position i of the serial stream.
  function automatic int bidx(input int i);
    return (LSB_FIRST != 0) ? i : (WIDTH - 1 - i);
  endfunction

  function automatic logic [WIDTH-1:0] rand_word();
    logic [31:0] r;
    r = $urandom();
    return r[WIDTH-1:0];
  endfunction

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_bit("start_busy", busy, 1'b1);
    chk_bit("start_valid", out_valid, 1'b0);
    chk_bit("start_perr", par_err, 1'b0);
  endtask

  // Send the WIDTH data bits; optional random idle cycles between bits.
  task automatic send_data(input logic [WIDTH-1:0] d, input bit gaps);
    for (int i = 0; i < WIDTH; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          ser_valid = 1'b0;
          ser_in    = $urandom_range(0, 1) == 1;
          tick();
          chk_bit("gap_busy", busy, 1'b1);
          chk_bit("gap_valid", out_valid, 1'b0);
        end
      end
      ser_in    = d[bidx(i)];
      ser_valid = 1'b1;
      tick();
      ser_valid = 1'b0;
      if (i < WIDTH - 1) begin
        chk_bit("bit_busy", busy, 1'b1);
        chk_bit("bit_valid", out_valid, 1'b0);
      end
    end
  endtask

  // Complete the frame (parity bit if present) and check the held word.
  task automatic finish_word(input logic [WIDTH-1:0] d);
`ifdef PARITY_CHK_EN
    chk_bit("prepar_busy", busy, 1'b1);
    chk_bit("prepar_valid", out_valid, 1'b0);
    ser_in    = ^d;
    ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
`endif
    chk_bit("word_valid", out_valid, 1'b1);
    chk_bit("word_busy", busy, 1'b0);
    chk_word("word_data", par_out, d);
    chk_bit("word_perr", par_err, 1'b0);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_bit("acc_valid", out_valid, 1'b0);
    chk_bit("acc_busy", busy, 1'b0);
  endtask

  initial begin
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] w2;
    bit               chained;

    // Reset state, before any clock edge.
    #2;
    chk_word("rst_data", par_out, {WIDTH{1'b0}});
    chk_bit("rst_valid", out_valid, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_ovr", overrun, 1'b0);
    chk_bit("rst_perr", par_err, 1'b0);
    tick();
    rst = 1'b0;
    tick();

    // Back-to-back bits, valid one cycle after the last bit.
    start_frame();
    send_data(16'hA5C3, 1'b0);
    finish_word(16'hA5C3);
    accept();

    // ser_valid toggling every cycle: 32 cycles for 16 bits.
    w = 16'hA5C3;
    start_frame();
    for (int c = 0; c < 2 * WIDTH; c++) begin
      ser_valid = (c % 2) == 1;
      ser_in    = w[bidx(c / 2)];
      tick();
      if (c < 2 * WIDTH - 1) begin
        chk_bit("tog_busy", busy, 1'b1);
        chk_bit("tog_valid", out_valid, 1'b0);
      end
    end
    ser_valid = 1'b0;
    finish_word(w);
    accept();

    // Overrun: start while a word is pending and not accepted.
    w = rand_word();
    start_frame();
    send_data(w, 1'b1);
    finish_word(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_bit("ovr_set", overrun, 1'b1);
    chk_word("ovr_data", par_out, w);
    chk_bit("ovr_valid", out_valid, 1'b1);
    chk_bit("ovr_busy", busy, 1'b0);
    tick();
    chk_word("ovr_stable", par_out, w);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_bit("ovr_clr", overrun, 1'b0);
    chk_word("ovr_clr_data", par_out, w);
    start   = 1'b1;
    clr_err = 1'b1;
    tick();
    start   = 1'b0;
    clr_err = 1'b0;
    chk_bit("ovr_prio", overrun, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk_bit("ovr_clr2", overrun, 1'b0);
    accept();

    // Restart after 7 bits: only the second word comes out.
    w = rand_word();
    start_frame();
    for (int i = 0; i < 7; i++) begin
      ser_in    = w[bidx(i)];
      ser_valid = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_bit("abort_busy", busy, 1'b1);
    chk_bit("abort_valid", out_valid, 1'b0);
    send_data(16'h1234, 1'b0);
    finish_word(16'h1234);
    accept();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_bit("single_word", out_valid, 1'b0);
    end

    // Handshake and start in the same cycle go straight to a new frame.
    w  = rand_word();
    w2 = rand_word();
    start_frame();
    send_data(w, 1'b1);
    finish_word(w);
    out_ready = 1'b1;
    start     = 1'b1;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk_bit("chain_busy", busy, 1'b1);
    chk_bit("chain_valid", out_valid, 1'b0);
    send_data(w2, 1'b1);
    finish_word(w2);
    accept();

    // Randomized frames with random hold time and optional chaining.
    chained = 1'b0;
    for (int k = 0; k < 12; k++) begin
      w = rand_word();
      if (!chained) begin
        start_frame();
      end
      send_data(w, 1'b1);
      finish_word(w);
      for (int h = 0; h < $urandom_range(0, 3); h++) begin
        tick();
        chk_bit("hold_valid", out_valid, 1'b1);
        chk_word("hold_data", par_out, w);
      end
      chained   = $urandom_range(0, 1) == 1;
      out_ready = 1'b1;
      start     = chained;
      tick();
      out_ready = 1'b0;
      start     = 1'b0;
      chk_bit("rnd_acc_valid", out_valid, 1'b0);
      chk_bit("rnd_acc_busy", busy, chained);
    end
    if (chained) begin
      w = rand_word();
      send_data(w, 1'b0);
      finish_word(w);
      accept();
    end

`ifdef PARITY_CHK_EN
    // Parity: 0x0001 has odd weight, so parity bit 0 is an error.
    start_frame();
    send_data(16'h0001, 1'b0);
    chk_bit("par_busy", busy, 1'b1);
    ser_in    = 1'b0;
    ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
    chk_bit("par_bad_valid", out_valid, 1'b1);
    chk_bit("par_bad_err", par_err, 1'b1);
    chk_word("par_bad_data", par_out, 16'h0001);
    accept();
    start_frame();
    send_data(16'h0001, 1'b0);
    ser_in    = 1'b1;
    ser_valid = 1'b1;
    tick();
    ser_valid = 1'b0;
    chk_bit("par_ok_valid", out_valid, 1'b1);
    chk_bit("par_ok_err", par_err, 1'b0);
    accept();
`endif

    // Reset mid-frame clears everything without a clock edge.
    w = rand_word();
    start_frame();
    for (int i = 0; i < 10; i++) begin
      ser_in    = w[bidx(i)];
      ser_valid = 1'b1;
      tick();
    end
    ser_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_word("mrst_data", par_out, {WIDTH{1'b0}});
    chk_bit("mrst_valid", out_valid, 1'b0);
    chk_bit("mrst_busy", busy, 1'b0);
    chk_bit("mrst_ovr", overrun, 1'b0);
    chk_bit("mrst_perr", par_err, 1'b0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      ser_in    = $urandom_range(0, 1) == 1;
      ser_valid = 1'b1;
      tick();
      chk_bit("nostart_valid", out_valid, 1'b0);
      chk_bit("nostart_busy", busy, 1'b0);
    end
    ser_valid = 1'b0;
    w = rand_word();
    start_frame();
    send_data(w, 1'b1);
    finish_word(w);
    accept();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
SERIAL_WORD_RX -- requirements
Module: serial_word_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data word width in bits (2..32).
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 = first received bit lands in par_out[0]; 0 = first received bit lands in par_out[WIDTH-1].
REQ-003 SHALL have port clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port start, input, 1: frame start request.
REQ-006 SHALL have port ser_in, input, 1: serial data bit.
REQ-007 SHALL have port ser_valid, input, 1: ser_in qualifier, one bit per cycle when high.
REQ-008 SHALL have port out_ready, input, 1: consumer accepts the word.
REQ-009 SHALL have port clr_err, input, 1: synchronous clear of sticky error flags.
REQ-010 SHALL have port par_out, output, WIDTH: assembled word.
REQ-011 SHALL have port out_valid, output, 1: par_out holds a complete word.
REQ-012 SHALL have port busy, output, 1: frame reception in progress.
REQ-013 SHALL have port overrun, output, 1: sticky, a start was lost while a word was pending.
REQ-014 SHALL have port par_err, output, 1: parity mismatch on the current word.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, PARITY (only when PARITY_CHK_EN is defined), and HOLD.
REQ-016 IDLE: start=1 SHALL move to SHIFT next cycle and clear the bit counter; ser_valid SHALL be ignored.
REQ-017 SHIFT: each cycle with ser_valid=1 SHALL accept ser_in and increment the counter; ser_valid=0 SHALL hold all state.
REQ-018 LSB_FIRST=1 SHALL shift right with ser_in entering the MSB; LSB_FIRST=0 SHALL shift left with ser_in entering the LSB.
REQ-019 Accepting the WIDTH-th bit SHALL move to PARITY if compiled in, otherwise to HOLD, in the following cycle.
REQ-020 start=1 in SHIFT or PARITY SHALL abort the frame, clear the counter and shift register, and remain in or return to SHIFT; no word is output.
REQ-021 busy SHALL be 1 exactly in SHIFT and PARITY.
REQ-022 HOLD: out_valid SHALL be 1; par_out SHALL remain stable until the cycle in which out_valid and out_ready are both 1.
REQ-023 HOLD handshake completion SHALL go to IDLE, or directly to SHIFT with the counter cleared if start=1 in the same cycle.
REQ-024 start=1 in HOLD without out_ready SHALL set overrun, leave HOLD and par_out unchanged, and discard the start.
REQ-025 Latency from the cycle the last bit (data or parity) is accepted to out_valid=1 SHALL be 1 cycle.
REQ-026 par_out outside HOLD SHALL show the in-progress shift register contents; consumers SHALL use it only when out_valid=1.
REQ-027 clr_err=1 SHALL clear overrun next cycle; a simultaneous set condition SHALL take priority.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, counter 0, par_out 0, and out_valid, busy, overrun and par_err to 0, regardless of clk.
REQ-029 Reset asserted mid-frame or in HOLD SHALL discard the partial or pending word; after rst falls, only a new start begins reception.

Configuration
REQ-030 With macro PARITY_CHK_EN defined, the block SHALL receive one even-parity bit after the data bits in state PARITY.
REQ-031 In that PARITY state, par_err SHALL be set to the XOR of the data bits and the parity bit on entry to HOLD, held through HOLD, and cleared on the next start.
REQ-032 Without PARITY_CHK_EN, the block SHALL have no PARITY state, SHALL tie par_err to 0, and frames SHALL be exactly WIDTH bits.

Verification
REQ-033 Bench SHALL run: WIDTH=16, LSB_FIRST=1, start, then 16 bits of 0xA5C3 sent LSB first with ser_valid=1 -> out_valid=1 one cycle after the last bit, par_out=0xA5C3.
REQ-034 Bench SHALL run: same word with ser_valid toggling 0/1 every cycle -> par_out=0xA5C3 after 32 cycles, busy=1 throughout the reception.
REQ-035 Bench SHALL run: word pending with out_ready=0, then start pulsed -> overrun=1, par_out unchanged; clr_err -> overrun=0.
REQ-036 Bench SHALL run: start pulsed again after 7 of 16 bits, then 16 bits of 0x1234 -> a single word 0x1234 is output.
REQ-037 Bench SHALL run: rst pulsed after 10 bits -> all outputs 0 immediately; ser_valid without a start produces no out_valid.
REQ-038 Bench SHALL run: with PARITY_CHK_EN, data 0x0001 followed by parity bit 0 -> par_err=1; with parity bit 1 -> par_err=0.
